// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes, byte-lane
// codes and the little-endian lane merge/extract helpers.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] merged;
        merged = word;
        case (lane)
            LANE_0:  merged[7:0]   = data;
            LANE_1:  merged[15:8]  = data;
            LANE_2:  merged[23:16] = data;
            LANE_3:  merged[31:24] = data;
            default: merged = word;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic        sigext);
        logic [7:0] b;
        case (lane)
            LANE_0:  b = word[7:0];
            LANE_1:  b = word[15:8];
            LANE_2:  b = word[23:16];
            LANE_3:  b = word[31:24];
            default: b = word[7:0];
        endcase
        return sigext ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, combinational read, synchronous clear on reset.
module dmem_array #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) mem[i] <= 32'd0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store target: one request at a time, fixed latency, one-cycle response.
//   state | meaning
//   IDLE  | ready for a request; captures it on req_valid
//   WAIT  | latency down-counter running; access happens when it reaches 0
//   RESP  | rsp_valid high for this single cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_sigext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic              cap_byte;
    logic              cap_sigext;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    logic [1:0]  lane;
    logic        misaligned;
    logic        access;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;

    assign lane       = cap_addr[1:0];
    assign misaligned = !cap_byte && (lane != LANE_0);
    assign access     = (state == ST_WAIT) && (cnt == 4'd0);
    assign mem_we     = access && cap_we && !misaligned;
    // Byte stores are a read-modify-write of the addressed word within the access edge.
    assign mem_wdata  = cap_byte ? lane_merge(mem_rdata, lane, cap_wdata[7:0]) : cap_wdata;

    dmem_array #(.IDX_W(ADDR_W - 2)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .idx   (cap_addr[ADDR_W-1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_byte   <= 1'b0;
            cap_sigext <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_byte   <= req_byte;
                        cap_sigext <= req_sigext;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_RESP;
                        rsp_err <= misaligned;
                        if (cap_we || misaligned)
                            rsp_rdata <= 32'd0;
                        else if (cap_byte)
                            rsp_rdata <= lane_extract(mem_rdata, lane, cap_sigext);
                        else
                            rsp_rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign stall     = req_valid & ~rsp_valid;

endmodule
